// File: rtl/audio_frame_fifo.sv
// Stereo frame FIFO behind the I2S receiver: captures {left,right} on the
// dataready strobe and presents frames through a registered FWFT valid/ready port.
module audio_frame_fifo #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int DEPTH_LOG2     = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SAMPLE_WIDTH-1:0]   wr_left,
  input  logic [SAMPLE_WIDTH-1:0]   wr_right,
  input  logic                      wr_strobe,
  output logic [SAMPLE_WIDTH-1:0]   rd_left,
  output logic [SAMPLE_WIDTH-1:0]   rd_right,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DEPTH_LOG2:0]       level,
  output logic                      full,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  input  logic                      clr_status
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FRAME_WIDTH = 2 * SAMPLE_WIDTH;
  localparam logic [DEPTH_LOG2:0] LEVEL_MAX = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DROP_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [FRAME_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr_next;
  logic [DEPTH_LOG2:0]    level_after_pop;
  logic [DEPTH_LOG2:0]    level_next;
  logic [FRAME_WIDTH-1:0] head_next;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // The next head comes straight from the write port when nothing else is left.
  always_comb begin
    pop             = rd_valid && rd_ready;
    push            = wr_strobe && (!full || pop);
    drop            = wr_strobe && full && !pop;
    rd_ptr_next     = rd_ptr + DEPTH_LOG2'(pop);
    level_after_pop = level - (DEPTH_LOG2+1)'(pop);
    level_next      = level_after_pop + (DEPTH_LOG2+1)'(push);
    head_next       = (level_after_pop == '0) ? {wr_left, wr_right} : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_left, wr_right};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_left    <= '0;
      rd_right   <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      rd_ptr   <= rd_ptr_next;
      level    <= level_next;
      full     <= (level_next == LEVEL_MAX);
      rd_valid <= (level_next != '0);
      // Head registers only move when a frame will be shown, so they hold while stalled.
      if (level_next != '0) {rd_left, rd_right} <= head_next;
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= clr_status ? DROP_CNT_WIDTH'(1)
                    : (drop_count == CNT_MAX) ? CNT_MAX
                    : drop_count + DROP_CNT_WIDTH'(1);
      end else if (clr_status) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Self-checking bench for audio_frame_fifo: directed scenarios plus random traffic
// compared against a queue-based frame model.
module tb_audio_frame_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wr_left, wr_right;
  logic        wr_strobe, rd_ready, clr_status;
  logic [15:0] rd_left, rd_right;
  logic        rd_valid, full, overflow;
  logic [4:0]  level;
  logic [7:0]  drop_count;
  logic [15:0] s_rd_left, s_rd_right;
  logic        s_rd_valid, s_full, s_overflow;
  logic [4:0]  s_level;
  logic [1:0]  s_drop_count;

  logic [31:0] q[$];
  bit          m_ovf;
  int          m_cnt8, m_cnt2;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  audio_frame_fifo #(.SAMPLE_WIDTH(16), .DEPTH_LOG2(4), .DROP_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .wr_left(wr_left), .wr_right(wr_right),
    .wr_strobe(wr_strobe), .rd_left(rd_left), .rd_right(rd_right),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level), .full(full),
    .overflow(overflow), .drop_count(drop_count), .clr_status(clr_status));

  audio_frame_fifo #(.SAMPLE_WIDTH(16), .DEPTH_LOG2(4), .DROP_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .wr_left(wr_left), .wr_right(wr_right),
    .wr_strobe(wr_strobe), .rd_left(s_rd_left), .rd_right(s_rd_right),
    .rd_valid(s_rd_valid), .rd_ready(rd_ready), .level(s_level), .full(s_full),
    .overflow(s_overflow), .drop_count(s_drop_count), .clr_status(clr_status));

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock: drive inputs at the falling edge, update the frame model at the
  // rising edge, return at the next falling edge with inputs idle.
  task automatic tick(input logic s, input logic r, input logic c,
                      input logic [15:0] l, input logic [15:0] rr);
    logic        pop, push, drop;
    logic [31:0] tmp;
    wr_strobe = s; rd_ready = r; clr_status = c; wr_left = l; wr_right = rr;
    @(posedge clk);
    pop  = (q.size() > 0) && r;
    push = s && ((q.size() < DEPTH) || pop);
    drop = s && (q.size() == DEPTH) && !pop;
    if (pop) tmp = q.pop_front();
    if (push) q.push_back({l, rr});
    if (drop) begin
      m_ovf  = 1'b1;
      m_cnt8 = c ? 1 : ((m_cnt8 == 255) ? 255 : m_cnt8 + 1);
      m_cnt2 = c ? 1 : ((m_cnt2 == 3) ? 3 : m_cnt2 + 1);
    end else if (c) begin
      m_ovf = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end
    @(negedge clk);
    wr_strobe = 1'b0; rd_ready = 1'b0; clr_status = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_strobe = 0; rd_ready = 0; clr_status = 0; wr_left = 0; wr_right = 0;
    #2 reset = 1'b0;
    q.delete(); m_ovf = 0; m_cnt8 = 0; m_cnt2 = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", rd_valid); end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_drop_count: got %0d want 0", drop_count); end
    vectors++; if ({rd_left, rd_right} !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 0", {rd_left, rd_right}); end
  endtask

  task automatic test_single_frame();
    tick(1, 0, 0, 16'h1234, 16'hABCD);
    for (int i = 0; i < 6; i++) begin
      vectors++; if (rd_valid !== 1'b1 || level !== 5'd1) begin miscompares++; $display("[TB] FAIL single_state cyc %0d: got valid %b level %0d want 1 1", i, rd_valid, level); end
      vectors++; if ({rd_left, rd_right} !== 32'h1234ABCD) begin miscompares++; $display("[TB] FAIL single_data cyc %0d: got %h want 1234abcd", i, {rd_left, rd_right}); end
      if (i < 5) tick(0, 0, 0, 16'hFFFF, 16'hFFFF);
    end
    tick(0, 1, 0, 0, 0);
    vectors++; if (rd_valid !== 1'b0 || level !== 5'd0) begin miscompares++; $display("[TB] FAIL single_pop: got valid %b level %0d want 0 0", rd_valid, level); end
  endtask

  task automatic test_fill_drop();
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 16'(i), ~16'(i));
    vectors++; if (level !== 5'd16 || full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_level: got level %0d full %b want 16 1", level, full); end
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 16'hDEAD + 16'(i), 16'hBEEF);
    vectors++; if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd3) begin miscompares++; $display("[TB] FAIL drop_status: got level %0d ovf %b cnt %0d want 16 1 3", level, overflow, drop_count); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (rd_valid !== 1'b1 || {rd_left, rd_right} !== {16'(i), ~16'(i)}) begin miscompares++; $display("[TB] FAIL drain_order %0d: got valid %b data %h want 1 %h", i, rd_valid, {rd_left, rd_right}, {16'(i), ~16'(i)}); end
      tick(0, 1, 0, 0, 0);
    end
    vectors++; if (rd_valid !== 1'b0 || level !== 5'd0) begin miscompares++; $display("[TB] FAIL drain_empty: got valid %b level %0d want 0 0", rd_valid, level); end
    tick(0, 0, 1, 0, 0);
    vectors++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin miscompares++; $display("[TB] FAIL fill_clear: got ovf %b cnt %0d want 0 0", overflow, drop_count); end
  endtask

  task automatic test_full_pop_write();
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 16'(100 + i), 16'(i));
    tick(1, 1, 0, 16'h5555, 16'hAAAA);
    vectors++; if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL fullpw_status: got level %0d full %b ovf %b want 16 1 0", level, full, overflow); end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] want;
      want = (i == 15) ? 32'h5555AAAA : {16'(101 + i), 16'(i + 1)};
      vectors++; if (rd_valid !== 1'b1 || {rd_left, rd_right} !== want) begin miscompares++; $display("[TB] FAIL fullpw_drain %0d: got %h want %h", i, {rd_left, rd_right}, want); end
      tick(0, 1, 0, 0, 0);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      tick(1, 1, 0, 16'(i), ~16'(i));
      vectors++; if (level !== 5'd1 || rd_valid !== 1'b1 || {rd_left, rd_right} !== {16'(i), ~16'(i)}) begin miscompares++; $display("[TB] FAIL wrap %0d: got level %0d valid %b data %h want 1 1 %h", i, level, rd_valid, {rd_left, rd_right}, {16'(i), ~16'(i)}); end
    end
    tick(0, 1, 0, 0, 0);
    vectors++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin miscompares++; $display("[TB] FAIL wrap_end: got valid %b ovf %b cnt %0d want 0 0 0", rd_valid, overflow, drop_count); end
  endtask

  task automatic test_saturation_clear();
    for (int i = 0; i < 21; i++) tick(1, 0, 0, 16'(i), 16'(i));
    vectors++; if (s_drop_count !== 2'd3 || s_overflow !== 1'b1 || drop_count !== 8'd5) begin miscompares++; $display("[TB] FAIL sat_count: got cnt2 %0d ovf2 %b cnt8 %0d want 3 1 5", s_drop_count, s_overflow, drop_count); end
    tick(0, 0, 1, 0, 0);
    vectors++; if (s_drop_count !== 2'd0 || s_overflow !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin miscompares++; $display("[TB] FAIL sat_clear: got cnt2 %0d ovf2 %b ovf %b cnt8 %0d want 0 0 0 0", s_drop_count, s_overflow, overflow, drop_count); end
    tick(1, 0, 1, 16'h7777, 16'h7777);
    vectors++; if (s_drop_count !== 2'd1 || s_overflow !== 1'b1 || overflow !== 1'b1 || drop_count !== 8'd1) begin miscompares++; $display("[TB] FAIL clear_vs_drop: got cnt2 %0d ovf2 %b ovf %b cnt8 %0d want 1 1 1 1", s_drop_count, s_overflow, overflow, drop_count); end
    for (int i = 0; i < 16; i++) tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int rdy_pct;
      rdy_pct = (i < 300) ? 20 : 75;
      tick($urandom_range(99) < 60, $urandom_range(99) < rdy_pct, $urandom_range(99) < 4,
           16'($urandom), 16'($urandom));
      vectors++; if (rd_valid !== (q.size() != 0) || s_rd_valid !== (q.size() != 0)) begin miscompares++; $display("[TB] FAIL rand_valid %0d: got %b/%b want %b", i, rd_valid, s_rd_valid, q.size() != 0); end
      vectors++; if (level !== 5'(q.size()) || s_level !== 5'(q.size()) || full !== (q.size() == DEPTH) || s_full !== (q.size() == DEPTH)) begin miscompares++; $display("[TB] FAIL rand_level %0d: got %0d/%0d full %b/%b want %0d", i, level, s_level, full, s_full, q.size()); end
      if (q.size() != 0) begin
        vectors++; if ({rd_left, rd_right} !== q[0] || {s_rd_left, s_rd_right} !== q[0]) begin miscompares++; $display("[TB] FAIL rand_data %0d: got %h/%h want %h", i, {rd_left, rd_right}, {s_rd_left, s_rd_right}, q[0]); end
      end
      vectors++; if (overflow !== m_ovf || s_overflow !== m_ovf || drop_count !== 8'(m_cnt8) || s_drop_count !== 2'(m_cnt2)) begin miscompares++; $display("[TB] FAIL rand_status %0d: got ovf %b/%b cnt %0d/%0d want %b %0d/%0d", i, overflow, s_overflow, drop_count, s_drop_count, m_ovf, m_cnt8, m_cnt2); end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(1, 0, 0, 16'(i + 1), 16'(i + 2));
    vectors++; if (level !== 5'd7) begin miscompares++; $display("[TB] FAIL areset_pre: got level %0d want 7", level); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (rd_valid !== 1'b0 || level !== 5'd0 || full !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_immediate: got valid %b level %0d full %b want 0 0 0", rd_valid, level, full); end
    q.delete(); m_ovf = 0; m_cnt8 = 0; m_cnt2 = 0;
    @(negedge clk);
    reset = 1'b1;
    tick(1, 0, 0, 16'hC0DE, 16'hF00D);
    vectors++; if (rd_valid !== 1'b1 || level !== 5'd1 || {rd_left, rd_right} !== 32'hC0DEF00D) begin miscompares++; $display("[TB] FAIL areset_first: got valid %b level %0d data %h want 1 1 c0def00d", rd_valid, level, {rd_left, rd_right}); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_drop();
    test_full_pop_write();
    test_wrap();
    test_saturation_clear();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
